uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 30 +++
 rtl/parity_calculator.sv | 14 +
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity constants and the prescale floor.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 5;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic                  parity_enable;
        logic                  parity_type;
        logic [PRESCALE_W-1:0] prescale;
    } tx_cfg_t;

    // Prescale values below the floor would make the bit too short to sample.
    function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
        return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
    endfunction

endpackage

// File: rtl/parity_calculator.sv
// Parity of a data word; shared between the UART transmitter and receiver.
module parity_calculator
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_type,
    output logic                  parity_bit_c
);

    assign parity_bit_c = (^data) ^ (parity_type == PARITY_ODD);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, LSB-first data, optional parity, stop; each bit held P clk cycles.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    input  logic                  data_valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  serial_data,
    output logic                  busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_next;
    tx_cfg_t               cfg_q, cfg_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [PRESCALE_W-1:0] cnt_q, cnt_next;
    logic [IDX_W-1:0]      idx_q, idx_next;
    logic                  bit_done_c;
    logic                  parity_bit_c;
    logic                  serial_next;
    logic                  busy_next;

    assign bit_done_c = (cnt_q == (eff_prescale(cfg_q.prescale) - PRESCALE_W'(1)));

    parity_calculator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data         (data_q),
        .parity_type  (cfg_q.parity_type),
        .parity_bit_c (parity_bit_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:   if (data_valid) state_next = ST_START;
            ST_START:  if (bit_done_c) state_next = ST_DATA;
            ST_DATA: begin
                if (bit_done_c && (idx_q == LAST_IDX)) begin
                    state_next = cfg_q.parity_enable ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (bit_done_c) state_next = ST_STOP;
            ST_STOP:   if (bit_done_c) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath next values: frame latch, bit-period counter, bit index, shifter
    always_comb begin
        cfg_next   = cfg_q;
        data_next  = data_q;
        shift_next = shift_q;
        cnt_next   = cnt_q;
        idx_next   = idx_q;
        if (state_q == ST_IDLE) begin
            cnt_next = '0;
            idx_next = '0;
            if (data_valid) begin
                cfg_next.parity_enable = parity_enable;
                cfg_next.parity_type   = parity_type;
                cfg_next.prescale      = prescale;
                data_next              = parallel_data;
                shift_next             = parallel_data;
            end
        end else begin
            cnt_next = bit_done_c ? '0 : cnt_q + PRESCALE_W'(1);
            if ((state_q == ST_DATA) && bit_done_c) begin
                idx_next   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                shift_next = shift_q >> 1;
            end
        end
    end

    // Output logic, evaluated on the upcoming state so the line is a clean flop
    always_comb begin
        serial_next = 1'b1;
        busy_next   = 1'b1;
        case (state_next)
            ST_IDLE:   busy_next   = 1'b0;
            ST_START:  serial_next = 1'b0;
            ST_DATA:   serial_next = shift_next[0];
            ST_PARITY: serial_next = parity_bit_c;
            ST_STOP:   serial_next = 1'b1;
            default:   busy_next   = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q       <= '0;
            data_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            serial_data <= 1'b1;
            busy        <= 1'b0;
        end else begin
            cfg_q       <= cfg_next;
            data_q      <= data_next;
            shift_q     <= shift_next;
            cnt_q       <= cnt_next;
            idx_q       <= idx_next;
            serial_data <= serial_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape, parity, spacing, ignored requests, reset abort.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] parallel_data;
    logic       data_valid;
    logic       parity_enable;
    logic       parity_type;
    logic [4:0] prescale;
    logic       serial_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .parallel_data (parallel_data),
        .data_valid    (data_valid),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .prescale      (prescale),
        .serial_data   (serial_data),
        .busy          (busy)
    );

    // Called at a falling edge; afterwards the bench sits in cycle T+1.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptype,
                        input logic [4:0] ps, input bit hold);
        parallel_data = d;
        parity_enable = pen;
        parity_type   = ptype;
        prescale      = ps;
        data_valid    = 1'b1;
        @(negedge clk);
        if (!hold) data_valid = 1'b0;
    endtask

    task automatic check_line(input string tag, input logic exp_s, input logic exp_b);
        checks++;
        assert ({serial_data, busy} === {exp_s, exp_b}) else begin
            errors++;
            $error("FAIL %s: serial=%b busy=%b, required serial=%b busy=%b",
                   tag, serial_data, busy, exp_s, exp_b);
        end
    endtask

    // Checks every cycle of a frame from T+1, then the idle cycle at T+N*P+1.
    // At cycle poke_at a one-cycle request with altered inputs is thrown at the DUT.
    task automatic check_frame(input string tag, input logic [7:0] d, input bit pen,
                               input logic exp_par, input int p, input int poke_at,
                               input logic [7:0] poke_data, input logic [4:0] poke_ps);
        logic seq [0:10];
        int   nbits;
        int   cyc;
        int   bad;
        logic last_s;
        logic last_b;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = d[i];
        if (pen) begin
            seq[9]  = exp_par;
            seq[10] = 1'b1;
            nbits   = 11;
        end else begin
            seq[9]  = 1'b1;
            seq[10] = 1'b1;
            nbits   = 10;
        end
        cyc = 0;
        for (int b = 0; b < nbits; b++) begin
            bad    = 0;
            last_s = serial_data;
            last_b = busy;
            for (int c = 0; c < p; c++) begin
                if (serial_data !== seq[b] || busy !== 1'b1) begin
                    bad++;
                    last_s = serial_data;
                    last_b = busy;
                end
                if (poke_at >= 0 && cyc == poke_at) begin
                    data_valid    = 1'b1;
                    parallel_data = poke_data;
                    prescale      = poke_ps;
                    parity_enable = ~parity_enable;
                    parity_type   = ~parity_type;
                end else if (poke_at >= 0 && cyc == poke_at + 1) begin
                    data_valid = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end
            checks++;
            assert (bad === 0) else begin
                errors++;
                $error("FAIL %s bit%0d: %0d of %0d cycles wrong, last serial=%b busy=%b, required serial=%b busy=1",
                       tag, b, bad, p, last_s, last_b, seq[b]);
            end
        end
        check_line({tag, "_end_idle"}, 1'b1, 1'b0);
    endtask

    task automatic check_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            if (serial_data !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s: %0d of %0d cycles not idle, required serial=1 busy=0", tag, bad, n);
        end
    endtask

    initial begin
        reset         = 1'b0;
        parallel_data = 8'h00;
        data_valid    = 1'b0;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        prescale      = 5'd8;
        repeat (3) @(negedge clk);
        check_line("reset_state", 1'b1, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_line("idle_after_release", 1'b1, 1'b0);

        // 0xA5, no parity, P=8: 0,1,0,1,0,0,1,0,1,1 -> busy 80 cycles
        send(8'hA5, 1'b0, 1'b0, 5'd8, 1'b0);
        check_frame("a5_p8", 8'hA5, 1'b0, 1'b0, 8, -1, 8'h00, 5'd0);

        // 0x0F with parity, P=16: even -> 0, odd -> 1; busy 176 cycles
        send(8'h0F, 1'b1, 1'b0, 5'd16, 1'b0);
        check_frame("0f_even", 8'h0F, 1'b1, 1'b0, 16, -1, 8'h00, 5'd0);
        send(8'h0F, 1'b1, 1'b1, 5'd16, 1'b0);
        check_frame("0f_odd", 8'h0F, 1'b1, 1'b1, 16, -1, 8'h00, 5'd0);

        // data_valid held high: 0x55 then 0x33 with exactly one idle cycle between
        send(8'h55, 1'b0, 1'b0, 5'd8, 1'b1);
        parallel_data = 8'h33;
        check_frame("b2b_55", 8'h55, 1'b0, 1'b0, 8, -1, 8'h00, 5'd0);
        @(negedge clk);
        data_valid = 1'b0;
        check_frame("b2b_33", 8'h33, 1'b0, 1'b0, 8, -1, 8'h00, 5'd0);
        check_idle("b2b_no_third", 12);

        // 0x96 even parity (bit 0); mid-frame 0xFF request must be dropped
        send(8'h96, 1'b1, 1'b0, 5'd8, 1'b0);
        check_frame("poke_ff", 8'h96, 1'b1, 1'b0, 8, 20, 8'hFF, 5'd3);
        check_idle("poke_no_extra", 100);

        // Reset during data bit 3 of 0xC3 (bit 3 = 0), then 0x3C cleanly
        send(8'hC3, 1'b0, 1'b0, 5'd8, 1'b0);
        repeat (34) @(negedge clk);
        check_line("pre_reset_bit3", 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_line("reset_immediate", 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_line("reset_held", 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_line("reset_released", 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0, 5'd8, 1'b0);
        check_frame("after_reset_3c", 8'h3C, 1'b0, 1'b0, 8, -1, 8'h00, 5'd0);

        // prescale=2 gives 4-cycle bits; prescale change mid-frame ignored
        send(8'h5A, 1'b0, 1'b0, 5'd2, 1'b0);
        check_frame("ps2_5a", 8'h5A, 1'b0, 1'b0, 4, 10, 8'h00, 5'd31);
        check_idle("ps2_no_extra", 10);

        // prescale=0 -> 4 cycles; 0x01 odd parity -> parity bit 0
        send(8'h01, 1'b1, 1'b1, 5'd0, 1'b0);
        check_frame("ps0_01_odd", 8'h01, 1'b1, 1'b0, 4, -1, 8'h00, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
